// File: rtl/led_stretch_pkg.sv
// Shared constants and helpers for the led_stretch output pulse stretcher.
package led_stretch_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam int DROP_W = 8;

    // Smallest w with 2**w >= value; callers always pass value >= 2.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

    function automatic int max2(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/led_stretch_ch.sv
// One led_stretch channel: IDLE/ON/GAP timer with a one-deep pending event.
// Optional per-channel drop counter under LED_STRETCH_DROP_CNT_EN.
module led_stretch_ch
    import led_stretch_pkg::*;
#(
    parameter int HOLD = 8,
    parameter int GAP  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pulse_i,
`ifdef LED_STRETCH_DROP_CNT_EN
    input  logic              drop_clr_i,
    output logic [DROP_W-1:0] drop_cnt_o,
`endif
    output logic              busy_o,
    output logic              on_d_o
);

    localparam int              CW       = clog2(max2(HOLD, GAP) + 1);
    localparam logic [CW-1:0]   HOLD_LD  = CW'(HOLD - 1);
    localparam logic [CW-1:0]   GAP_LD   = CW'(GAP - 1);
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1'b1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          cnt_zero_s;

    assign cnt_zero_s = (cnt_q == CNT_ZERO);

    // Next-state logic; a pulse in the last GAP cycle restarts ON directly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        case (state_q)
            S_IDLE: begin
                if (pulse_i) begin
                    state_d = S_ON;
                    cnt_d   = HOLD_LD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ON: begin
                if (cnt_zero_s) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
                pend_d = pend_q | pulse_i;
            end
            S_GAP: begin
                if (!cnt_zero_s) begin
                    cnt_d  = cnt_q - CNT_ONE;
                    pend_d = pend_q | pulse_i;
                end else if (pend_q || pulse_i) begin
                    state_d = S_ON;
                    cnt_d   = HOLD_LD;
                    pend_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
                pend_d  = 1'b0;
            end
        endcase
    end

    // State, counter and pending registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    assign busy_o = (state_q != S_IDLE) | pend_q;
    assign on_d_o = (state_d == S_ON);

`ifdef LED_STRETCH_DROP_CNT_EN
    logic              drop_s;
    logic [DROP_W-1:0] drop_q;

    // pend_q is only ever set outside IDLE, so any pulse against it is a drop.
    assign drop_s = pulse_i & pend_q;

    // Saturating drop counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_q <= {DROP_W{1'b0}};
        end else if (drop_clr_i) begin
            drop_q <= {DROP_W{1'b0}};
        end else if (drop_s && (drop_q != {DROP_W{1'b1}})) begin
            drop_q <= drop_q + DROP_W'(1'b1);
        end else begin
            drop_q <= drop_q;
        end
    end

    assign drop_cnt_o = drop_q;
`endif

endmodule

// File: rtl/led_stretch.sv
// led_stretch top: NCH pulse stretchers, level OR-in and polarity on a registered pin drive.
// Optional drop counters (drop_clr / drop_cnt ports) under LED_STRETCH_DROP_CNT_EN.
module led_stretch
    import led_stretch_pkg::*;
#(
    parameter int NCH      = 4,
    parameter bit polarity = 1'b1,
    parameter int HOLD     = 2500000,
    parameter int GAP      = 1250000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        pulse_in,
    input  logic [NCH-1:0]        level_in,
    output logic [NCH-1:0]        hw_out,
    output logic [NCH-1:0]        busy
`ifdef LED_STRETCH_DROP_CNT_EN
    ,
    input  logic                  drop_clr,
    output logic [NCH*DROP_W-1:0] drop_cnt
`endif
);

    logic [NCH-1:0] on_d_s;
    logic [NCH-1:0] busy_s;
    logic [NCH-1:0] hw_out_d;
    logic [NCH-1:0] hw_out_q;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        led_stretch_ch #(
            .HOLD (HOLD),
            .GAP  (GAP)
        ) u_ch (
            .clk_i      (clk),
            .rst_i      (rst),
            .pulse_i    (pulse_in[g]),
`ifdef LED_STRETCH_DROP_CNT_EN
            .drop_clr_i (drop_clr),
            .drop_cnt_o (drop_cnt[g*DROP_W +: DROP_W]),
`endif
            .busy_o     (busy_s[g]),
            .on_d_o     (on_d_s[g])
        );
    end

    // Built from next-state and raw level_in so the pin register doubles as level_r.
    always_comb begin
        if (polarity) begin
            hw_out_d = level_in | on_d_s;
        end else begin
            hw_out_d = ~(level_in | on_d_s);
        end
    end

    // Pin drive register; reset forces the inactive level.
    always_ff @(posedge clk) begin
        if (rst) begin
            hw_out_q <= polarity ? {NCH{1'b0}} : {NCH{1'b1}};
        end else begin
            hw_out_q <= hw_out_d;
        end
    end

    assign hw_out = hw_out_q;
    assign busy   = busy_s;

endmodule

// File: tb/tb_led_stretch.sv
// Self-checking bench for led_stretch (NCH=2, HOLD=8, GAP=4), both polarities side by side.
module tb_led_stretch;

    localparam int NCH  = 2;
    localparam int HOLD = 8;
    localparam int GAP  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       drop_clr;
    logic [1:0] pulse_in;
    logic [1:0] level_in;
    wire  [1:0] hw_lo, hw_hi, busy_lo, busy_hi;
`ifdef LED_STRETCH_DROP_CNT_EN
    wire  [15:0] dc_lo, dc_hi;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: each channel is "ON from m_start for HOLD cycles, then GAP off".
    int m_start [2];
    bit m_pend  [2];
    bit m_lvl   [2];
    int m_drop  [2];

    always #5 clk = ~clk;

    led_stretch #(.NCH(NCH), .polarity(1'b0), .HOLD(HOLD), .GAP(GAP)) dut_lo (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .level_in(level_in),
        .hw_out(hw_lo), .busy(busy_lo)
`ifdef LED_STRETCH_DROP_CNT_EN
        , .drop_clr(drop_clr), .drop_cnt(dc_lo)
`endif
    );

    led_stretch #(.NCH(NCH), .polarity(1'b1), .HOLD(HOLD), .GAP(GAP)) dut_hi (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .level_in(level_in),
        .hw_out(hw_hi), .busy(busy_hi)
`ifdef LED_STRETCH_DROP_CNT_EN
        , .drop_clr(drop_clr), .drop_cnt(dc_hi)
`endif
    );

    function automatic bit e_act(input int ch);
        return m_lvl[ch] | ((cyc >= m_start[ch]) && (cyc < m_start[ch] + HOLD));
    endfunction

    function automatic bit e_busy(input int ch);
        return ((cyc >= m_start[ch]) && (cyc < m_start[ch] + HOLD + GAP)) || m_pend[ch];
    endfunction

    // Apply inputs for the current cycle, advance the model and the clock.
    task automatic tick(input logic [1:0] p, input logic [1:0] l, input logic r, input logic c);
        pulse_in = p;
        level_in = l;
        rst      = r;
        drop_clr = c;
        for (int ch = 0; ch < NCH; ch++) begin
            if (r) begin
                m_start[ch] = -1000;
                m_pend[ch]  = 1'b0;
                m_lvl[ch]   = 1'b0;
                m_drop[ch]  = 0;
            end else begin
                if (p[ch]) begin
                    if (cyc >= m_start[ch] + HOLD + GAP) m_start[ch] = cyc + 1;
                    else if (m_pend[ch]) m_drop[ch] = (m_drop[ch] < 255) ? m_drop[ch] + 1 : 255;
                    else m_pend[ch] = 1'b1;
                end
                if (c) m_drop[ch] = 0;
                m_lvl[ch] = l[ch];
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int ch = 0; ch < NCH; ch++) begin
            if (m_pend[ch] && (cyc == m_start[ch] + HOLD + GAP)) begin
                m_start[ch] = cyc;
                m_pend[ch]  = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        tick(2'b00, 2'b00, 1'b1, 1'b0);
        tick(2'b11, 2'b11, 1'b1, 1'b0);
        tick(2'b00, 2'b00, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (hw_lo !== 2'b11) begin
            errors++; $display("FAIL reset_hw_lo got=%b exp=11", hw_lo);
        end
        checks++;
        if (hw_hi !== 2'b00) begin
            errors++; $display("FAIL reset_hw_hi got=%b exp=00", hw_hi);
        end
        checks++;
        if (busy_lo !== 2'b00 || busy_hi !== 2'b00) begin
            errors++; $display("FAIL reset_busy got=%b/%b exp=00", busy_lo, busy_hi);
        end
    endtask

    task automatic test_single();
        bit a, b;
        do_reset();
        for (int k = 0; k < 36; k++) begin
            tick((k == 10) ? 2'b01 : 2'b00, 2'b00, 1'b0, 1'b0);
            a = (k + 1 >= 11) && (k + 1 <= 18);
            b = (k + 1 >= 11) && (k + 1 <= 22);
            checks++;
            if (hw_hi !== {1'b0, a} || hw_lo !== ~{1'b0, a}) begin
                errors++; $display("FAIL single_hw t=%0d got=%b/%b exp_active=%b", k + 1, hw_hi, hw_lo, a);
            end
            checks++;
            if (busy_hi !== {1'b0, b} || busy_lo !== {1'b0, b}) begin
                errors++; $display("FAIL single_busy t=%0d got=%b exp=%b", k + 1, busy_hi, {1'b0, b});
            end
        end
    endtask

    task automatic test_pend();
        bit a, b;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            tick((k == 10 || k == 13 || k == 14) ? 2'b01 : 2'b00, 2'b00, 1'b0, 1'b0);
            a = ((k + 1 >= 11) && (k + 1 <= 18)) || ((k + 1 >= 23) && (k + 1 <= 30));
            b = (k + 1 >= 11) && (k + 1 <= 34);
            checks++;
            if (hw_hi !== {1'b0, a} || hw_lo !== ~{1'b0, a}) begin
                errors++; $display("FAIL pend_hw t=%0d got=%b/%b exp_active=%b", k + 1, hw_hi, hw_lo, a);
            end
            checks++;
            if (busy_hi !== {1'b0, b}) begin
                errors++; $display("FAIL pend_busy t=%0d got=%b exp=%b", k + 1, busy_hi, {1'b0, b});
            end
        end
`ifdef LED_STRETCH_DROP_CNT_EN
        checks++;
        if (dc_hi !== 16'h0001 || dc_lo !== 16'h0001) begin
            errors++; $display("FAIL pend_drop got=%h/%h exp=0001", dc_hi, dc_lo);
        end
`endif
    endtask

    task automatic test_level();
        bit a, b;
        do_reset();
        for (int k = 0; k < 50; k++) begin
            tick({(k == 20), 1'b0}, {(k >= 5 && k <= 40), 1'b0}, 1'b0, 1'b0);
            a = (k + 1 >= 6) && (k + 1 <= 41);
            b = (k + 1 >= 21) && (k + 1 <= 32);
            checks++;
            if (hw_hi !== {a, 1'b0} || hw_lo !== ~{a, 1'b0}) begin
                errors++; $display("FAIL level_hw t=%0d got=%b/%b exp_active=%b", k + 1, hw_hi, hw_lo, a);
            end
            checks++;
            if (busy_hi !== {b, 1'b0}) begin
                errors++; $display("FAIL level_busy t=%0d got=%b exp=%b", k + 1, busy_hi, {b, 1'b0});
            end
        end
    endtask

    task automatic test_reset_mid();
        bit a;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            tick((k == 10 || k == 12) ? 2'b01 : 2'b00, 2'b00, (k == 14), 1'b0);
            a = (k + 1 >= 11) && (k + 1 <= 14);
            checks++;
            if (hw_hi !== {1'b0, a} || hw_lo !== ~{1'b0, a}) begin
                errors++; $display("FAIL rstmid_hw t=%0d got=%b/%b exp_active=%b", k + 1, hw_hi, hw_lo, a);
            end
            checks++;
            if (busy_hi !== {1'b0, a}) begin
                errors++; $display("FAIL rstmid_busy t=%0d got=%b exp=%b", k + 1, busy_hi, {1'b0, a});
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] p, l;
        logic       r, c;
        bit [1:0]   ea, eb;
        l = 2'b00;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            p[0] = ($urandom_range(3) == 0);
            p[1] = ($urandom_range(4) == 0);
            if ($urandom_range(19) == 0) l[0] = ~l[0];
            if ($urandom_range(19) == 0) l[1] = ~l[1];
            r = ($urandom_range(299) == 0);
            c = ($urandom_range(49) == 0);
            tick(p, l, r, c);
            ea = {e_act(1), e_act(0)};
            eb = {e_busy(1), e_busy(0)};
            checks++;
            if (hw_hi !== ea || hw_lo !== ~ea) begin
                errors++; $display("FAIL rand_hw t=%0d got=%b/%b exp_active=%b", cyc, hw_hi, hw_lo, ea);
            end
            checks++;
            if (busy_hi !== eb || busy_lo !== eb) begin
                errors++; $display("FAIL rand_busy t=%0d got=%b/%b exp=%b", cyc, busy_hi, busy_lo, eb);
            end
`ifdef LED_STRETCH_DROP_CNT_EN
            checks++;
            if (dc_hi !== {m_drop[1][7:0], m_drop[0][7:0]}) begin
                errors++; $display("FAIL rand_drop t=%0d got=%h exp=%h", cyc, dc_hi, {m_drop[1][7:0], m_drop[0][7:0]});
            end
`endif
        end
    endtask

`ifdef LED_STRETCH_DROP_CNT_EN
    task automatic test_drop_sat();
        do_reset();
        for (int k = 0; k < 330; k++) begin
            tick(2'b01, 2'b00, 1'b0, 1'b0);
        end
        checks++;
        if (dc_hi !== 16'h00ff || dc_lo !== 16'h00ff) begin
            errors++; $display("FAIL drop_sat got=%h/%h exp=00ff", dc_hi, dc_lo);
        end
        tick(2'b01, 2'b00, 1'b0, 1'b1);
        checks++;
        if (dc_hi !== 16'h0000 || dc_lo !== 16'h0000) begin
            errors++; $display("FAIL drop_clr got=%h/%h exp=0000", dc_hi, dc_lo);
        end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        drop_clr = 1'b0;
        pulse_in = 2'b00;
        level_in = 2'b00;
        for (int ch = 0; ch < NCH; ch++) begin
            m_start[ch] = -1000;
            m_pend[ch]  = 1'b0;
            m_lvl[ch]   = 1'b0;
            m_drop[ch]  = 0;
        end
        test_reset();
        test_single();
        test_pend();
        test_level();
        test_reset_mid();
        test_random();
`ifdef LED_STRETCH_DROP_CNT_EN
        test_drop_sat();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_stretch.md
Name: led_stretch

Overview:
- Output-side counterpart of the button debouncer: turns clean, single-cycle internal events into HW pin activity that lasts long enough to be seen or heard (LEDs, buzzer).
- Each channel stretches a one-cycle pulse to a fixed minimum on-time, then enforces a minimum off-gap, so back-to-back events stay distinguishable.
- Sits between the RTS status/event logic and the board output pins.
- Per-pin polarity is handled here, the same way the debouncer handles input polarity.

Parameters:
- NCH, 4, number of independent channels (1..16).
- polarity, 1, 1 => hw_out is active high; 0 => active low (all channels).
- HOLD, 2500000, on-time in clk cycles per stretched pulse (>=1; 50 ms at 50 MHz).
- GAP, 1250000, forced off-time in clk cycles after each stretched pulse (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- pulse_in  in  NCH  one-cycle event requests, clk domain, no sync needed
- level_in  in  NCH  steady on-requests, ORed onto the output
- hw_out  out  NCH  pin drive, polarity applied, registered
- busy  out  NCH  channel is in ON or GAP, or has a pending event

Behaviour:
- Channel state machine, one per channel, states IDLE, ON, GAP. Counter width is clog2(max(HOLD,GAP)+1).
- IDLE:
  - pulse_in=1 -> ON with cnt=HOLD-1.
- ON:
  - cnt decrements each cycle.
  - At cnt==0 -> GAP with cnt=GAP-1.
  - ON lasts exactly HOLD cycles.
- GAP:
  - cnt decrements each cycle.
  - At cnt==0 -> ON (cnt=HOLD-1) if pending=1, clearing pending; otherwise -> IDLE.
- Pending flag, one deep:
  - pulse_in=1 while in ON or GAP sets pending.
  - pulse_in=1 while pending is already set is dropped and does not retrigger.
  - pulse_in=1 in the last GAP cycle (cnt==0) is treated as pending, so the channel goes directly to ON.
- Output:
  - active = level_r | (state==ON), where level_r is level_in registered.
  - hw_out = polarity ? active : ~active, registered.
- Latency: 1 cycle from pulse_in or level_in to hw_out. A pulse at cycle t gives hw_out active on cycles t+1 .. t+HOLD.
- level_in does not affect the state machine or timing. While level_in=1, stretched pulses are invisible but still timed.
- busy = (state!=IDLE) | pending, combinational from registers.
- Reset:
  - all channels go to IDLE, cnt=0, pending=0, level_r=0.
  - hw_out = inactive level: all 0 if polarity=1, all 1 if polarity=0.
  - busy=0.
  - Reset mid-ON/GAP abandons the event and any pending event; the output goes inactive on the next cycle.
  - pulse_in in the same cycle as rst is ignored.
- Channels are fully independent. Simultaneous pulses on several channels are all accepted.

Optional Feature:
- Macro LED_STRETCH_DROP_CNT_EN.
- Defined:
  - adds output drop_cnt [NCH*8] plus input drop_clr [1].
  - Per channel, an 8-bit saturating counter increments when pulse_in is dropped (pending already set). It holds at 255.
  - drop_clr=1 zeroes all counters; it has priority over an increment in the same cycle.
  - Reset zeroes the counters.
- Undefined: no counters, no extra ports. Drops are silent; all other behaviour is identical.

Decomposition:
- Package led_stretch_pkg:
  - state encoding localparams S_IDLE=2'd0, S_ON=2'd1, S_GAP=2'd2.
  - DROP_W=8.
  - counter-width function clog2.
- Sub-module led_stretch_ch: one channel (FSM, counter, pending, optional drop counter), parameters HOLD/GAP.
- Top level: NCH generate-instances of led_stretch_ch, level_in register, polarity/output register.

Test Plan (sim with HOLD=8, GAP=4, NCH=2):
- Reset values: rst high 3 cycles, polarity=0 -> hw_out=2'b11, busy=0. Same with polarity=1 -> hw_out=2'b00.
- Single pulse: pulse_in[0] at t=10 -> hw_out[0] active t=11..18, inactive t=19 onward. busy[0] high t=11..22, low t=23. Channel 1 stays idle.
- Pulse during ON: pulses at t=10 and t=13 -> second ON on t=23..30 with exactly 4 inactive cycles between. A third pulse at t=14 is dropped; drop_cnt[0]=1 with LED_STRETCH_DROP_CNT_EN.
- level_in: level_in[1]=1 at t=5..40 -> hw_out[1] active t=6..41. A pulse at t=20 still makes busy[1] high t=21..32.
- Reset mid-operation: pulse at t=10, rst at t=14 -> hw_out[0] inactive from t=15. busy=0, pending cleared, no later ON.
- Drop counter saturation (macro on): 300 dropped pulses -> drop_cnt[0]=255. drop_clr together with a drop in the same cycle -> 0.
